// File: rtl/modulo_gerenciador_rolhas_param.sv
// modulo_gerenciador_rolhas_param: cork reservoir/feeder manager; in: clk rst enable cap_pulse op_valid op_qty; out: op_ack op_reject reservoir feeder ro low_stock cap_err busy state
module modulo_gerenciador_rolhas_param #(
  parameter int RES_W    = 7,
  parameter int RES_MAX  = 99,
  parameter int RES_INIT = 20,
  parameter int FEED_W   = 5,
  parameter int FEED_MAX = 20,
  parameter int FEED_MIN = 5,
  parameter int BATCH    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cap_pulse,
  input  logic              op_valid,
  input  logic [RES_W-1:0]  op_qty,
  output logic              op_ack,
  output logic              op_reject,
  output logic [RES_W-1:0]  reservoir,
  output logic [FEED_W-1:0] feeder,
  output logic              ro,
  output logic              low_stock,
  output logic              cap_err,
  output logic              busy,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {IDLE = 2'b00, TRANSFER = 2'b01, LOAD = 2'b10} state_t;
  localparam logic [RES_W-1:0] R_INIT = RES_W'(RES_INIT);
  state_t st, st_n;
  logic [FEED_W-1:0] batch_cnt, feed_n;
  logic [RES_W-1:0] res_n;
  logic [RES_W:0] sum;
  logic move, ack_n, rej_n, err_n;
  assign sum = {1'b0, reservoir} + {1'b0, op_qty};
  assign move = st == TRANSFER && enable && reservoir != '0 && int'(feeder) < FEED_MAX;
  assign feed_n = move ? (cap_pulse ? feeder : feeder + FEED_W'(1))
                : (cap_pulse && feeder != '0) ? feeder - FEED_W'(1) : feeder;
  assign err_n = cap_pulse && feeder == '0 && !move;
  assign ro = feeder == '0;
  assign low_stock = int'(reservoir) < BATCH;
  assign busy = st == TRANSFER;
  assign state = st;
  always_comb begin
    st_n = st;
    res_n = reservoir;
    ack_n = 1'b0;
    rej_n = 1'b0;
    unique case (st)
      IDLE: st_n = op_valid ? LOAD
                 : (enable && int'(feeder) < FEED_MIN && reservoir != '0) ? TRANSFER : IDLE;
      TRANSFER: begin
        res_n = move ? reservoir - RES_W'(1) : reservoir;
        st_n = (!move || int'(batch_cnt) + 1 >= BATCH || reservoir == RES_W'(1)
                || int'(feed_n) == FEED_MAX) ? IDLE : TRANSFER;
      end
      LOAD: begin
        ack_n = int'(sum) <= RES_MAX;
        rej_n = !ack_n;
        res_n = ack_n ? sum[RES_W-1:0] : reservoir;
        st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      reservoir <= R_INIT;
      feeder <= '0;
      batch_cnt <= '0;
      op_ack <= 1'b0;
      op_reject <= 1'b0;
      cap_err <= 1'b0;
    end else begin
      st <= st_n;
      reservoir <= res_n;
      feeder <= feed_n;
      batch_cnt <= (st == IDLE) ? '0 : batch_cnt + FEED_W'(move);
      op_ack <= ack_n;
      op_reject <= rej_n;
      cap_err <= err_n;
    end
  end
endmodule

// File: tb/tb_modulo_gerenciador_rolhas_param.sv
// tb_modulo_gerenciador_rolhas_param: directed plus random check against a cork-count model
module tb_modulo_gerenciador_rolhas_param;
  localparam int RES_W = 7, RES_MAX = 99, RES_INIT = 20;
  localparam int FEED_W = 5, FEED_MAX = 20, FEED_MIN = 5, BATCH = 15;
  logic clk = 0, rst = 1, enable = 0, cap_pulse = 0, op_valid = 0;
  logic [RES_W-1:0] op_qty = '0;
  logic op_ack, op_reject, ro, low_stock, cap_err, busy;
  logic [RES_W-1:0] reservoir;
  logic [FEED_W-1:0] feeder;
  logic [1:0] state;
  int n_cmp = 0, n_bad = 0;
  int m_state = 0, m_res = RES_INIT, m_feed = 0, m_batch = 0;
  bit m_ack = 0, m_rej = 0, m_err = 0;
  int f0, r0;
  modulo_gerenciador_rolhas_param #(
    .RES_W(RES_W), .RES_MAX(RES_MAX), .RES_INIT(RES_INIT), .FEED_W(FEED_W),
    .FEED_MAX(FEED_MAX), .FEED_MIN(FEED_MIN), .BATCH(BATCH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cap_pulse(cap_pulse), .op_valid(op_valid),
    .op_qty(op_qty), .op_ack(op_ack), .op_reject(op_reject), .reservoir(reservoir),
    .feeder(feeder), .ro(ro), .low_stock(low_stock), .cap_err(cap_err), .busy(busy),
    .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model();
    int nm;
    bit mv;
    if (rst) begin
      m_state = 0; m_res = RES_INIT; m_feed = 0; m_batch = 0;
      m_ack = 0; m_rej = 0; m_err = 0;
      return;
    end
    m_ack = 0; m_rej = 0; m_err = 0;
    nm = m_state;
    mv = m_state == 1 && enable && m_res > 0 && m_feed < FEED_MAX;
    if (m_state == 0) begin
      if (op_valid) nm = 2;
      else if (enable && m_feed < FEED_MIN && m_res > 0) begin nm = 1; m_batch = 0; end
    end else if (m_state == 2) begin
      if (m_res + int'(op_qty) <= RES_MAX) begin m_res += int'(op_qty); m_ack = 1; end
      else m_rej = 1;
      nm = 0;
    end else if (!mv) nm = 0;
    if (mv) begin
      m_res--; m_batch++;
      if (!cap_pulse) m_feed++;
    end else if (cap_pulse) begin
      if (m_feed > 0) m_feed--;
      else m_err = 1;
    end
    if (mv && (m_batch == BATCH || m_res == 0 || m_feed == FEED_MAX)) nm = 0;
    m_state = nm;
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("state", int'(state), m_state);
    chk("reservoir", int'(reservoir), m_res);
    chk("feeder", int'(feeder), m_feed);
    chk("op_ack", int'(op_ack), int'(m_ack));
    chk("op_reject", int'(op_reject), int'(m_rej));
    chk("cap_err", int'(cap_err), int'(m_err));
    chk("ro", int'(ro), int'(m_feed == 0));
    chk("low_stock", int'(low_stock), int'(m_res < BATCH));
    chk("busy", int'(busy), int'(m_state == 1));
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    rst = 1; tick(); rst = 0;
    chk("rst_res", int'(reservoir), 20);
    chk("rst_feed", int'(feeder), 0);
    chk("rst_ro", int'(ro), 1);
    chk("rst_state", int'(state), 0);
    enable = 1; run(16);
    chk("batch_feed", int'(feeder), 15);
    chk("batch_res", int'(reservoir), 5);
    chk("batch_busy", int'(busy), 0);
    chk("batch_low", int'(low_stock), 1);
    enable = 0; op_valid = 1; op_qty = 50; run(2);
    chk("load_ack", int'(op_ack), 1);
    chk("load_res", int'(reservoir), 55);
    op_valid = 0; tick();
    op_valid = 1; run(2);
    chk("over_rej", int'(op_reject), 1);
    chk("over_ack", int'(op_ack), 0);
    chk("over_res", int'(reservoir), 55);
    op_valid = 0; tick();
    rst = 1; tick(); rst = 0;
    enable = 1; run(16);
    enable = 0; cap_pulse = 1; run(13); cap_pulse = 0;
    enable = 1; run(3);
    enable = 0; tick();
    chk("abort_feed", int'(feeder), 4);
    chk("abort_res", int'(reservoir), 3);
    enable = 1; run(4);
    chk("empty_feed", int'(feeder), 7);
    chk("empty_res", int'(reservoir), 0);
    chk("empty_ro", int'(ro), 0);
    chk("empty_busy", int'(busy), 0);
    enable = 0; op_valid = 1; op_qty = 50; run(2); op_valid = 0;
    cap_pulse = 1; run(7); tick();
    chk("cap_err", int'(cap_err), 1);
    chk("cap_err_feed", int'(feeder), 0);
    cap_pulse = 0;
    enable = 1; run(6);
    enable = 0; tick();
    chk("drop_state", int'(state), 0);
    chk("drop_feed", int'(feeder), 5);
    chk("drop_res", int'(reservoir), 45);
    run(3);
    chk("drop_stay", int'(state), 0);
    cap_pulse = 1; tick();
    enable = 1; tick();
    f0 = int'(feeder); r0 = int'(reservoir);
    run(5);
    chk("capx_feed", int'(feeder), f0);
    chk("capx_res", int'(reservoir), r0 - 5);
    cap_pulse = 0; run(10);
    enable = 0; cap_pulse = 1; run(10); cap_pulse = 0;
    enable = 1; run(3);
    rst = 1; op_valid = 1; tick();
    chk("mid_rst_res", int'(reservoir), 20);
    chk("mid_rst_feed", int'(feeder), 0);
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_ack", int'(op_ack), 0);
    rst = 0; op_valid = 0; enable = 0; tick();
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      enable = $urandom_range(0, 7) != 0;
      cap_pulse = $urandom_range(0, 3) == 0;
      if (!op_valid && $urandom_range(0, 11) == 0) begin
        op_valid = 1;
        op_qty = RES_W'($urandom_range(0, 2 ** RES_W - 1));
      end
      tick();
      if (m_ack || m_rej) op_valid = $urandom_range(0, 9) == 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
